// File: rtl/arbiter3_pkg.sv
// Shared types, context-vector layout and selection helpers for the
// 3-client arbiter wrapper.
package arbiter3_pkg;

  localparam int NCLIENT = 3;
  localparam int CTX_W   = 12;

  localparam int CTX_REQ_LSB = 0;
  localparam int CTX_GNT_LSB = 3;
  localparam int CTX_PTR_LSB = 6;
  localparam int CTX_PND_LSB = 9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RECOVER = 2'd2
  } state_t;

  // First requester at or after the pointer position, wrapping mod 3.
  function automatic logic [NCLIENT-1:0] rr_pick(input logic [NCLIENT-1:0] req,
                                                 input logic [NCLIENT-1:0] ptr);
    logic [NCLIENT-1:0] pick;
    int start;
    int idx;
    pick  = '0;
    start = ptr[1] ? 1 : (ptr[2] ? 2 : 0);
    for (int i = NCLIENT - 1; i >= 0; i--) begin
      idx = (start + i) % NCLIENT;
      if (req[idx]) pick = NCLIENT'(1 << idx);
    end
    return pick;
  endfunction

  function automatic logic is_onehot3(input logic [NCLIENT-1:0] v);
    return (v != '0) && ((v & (v - 3'd1)) == '0);
  endfunction

  function automatic logic [NCLIENT-1:0] rotl3(input logic [NCLIENT-1:0] v);
    return {v[NCLIENT-2:0], v[NCLIENT-1]};
  endfunction

endpackage

// File: rtl/arbiter3_rr_pick.sv
// Combinational round-robin fallback selector used when the Skolem
// candidate grant is rejected.
module arbiter3_rr_pick
  import arbiter3_pkg::*;
(
  input  logic [NCLIENT-1:0] req,
  input  logic [NCLIENT-1:0] ptr,
  output logic [NCLIENT-1:0] pick
);

  assign pick = rr_pick(req, ptr);

endmodule

// File: rtl/arbiter3_grant_ctrl.sv
// Sequential wrapper around the 3-client Skolem grant network.
// Optional forced release after TIMEOUT hold cycles: define ARB3_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for any registered request; latches candidate or fallback
// GRANT   | one-hot grant held until owner releases (or hold timeout)
// RECOVER | single gnt=0 cycle so ctx settles before re-arbitration
module arbiter3_grant_ctrl
  import arbiter3_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCLIENT-1:0] req,
  input  logic [NCLIENT-1:0] rel,
  input  logic [NCLIENT-1:0] skg,
  output logic [CTX_W-1:0]   ctx,
  output logic [NCLIENT-1:0] gnt,
  output logic               busy,
  output logic               err,
  output logic               tmo
);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("arbiter3_grant_ctrl: TIMEOUT must be within 2..255");
  end

  state_t             state_q, state_d;
  logic [NCLIENT-1:0] req_q;
  logic [NCLIENT-1:0] gnt_q, gnt_d;
  logic [NCLIENT-1:0] ptr_q, ptr_d;
  logic               err_q, err_d;
  logic [NCLIENT-1:0] fb_pick;
  logic               cand_ok;

  arbiter3_rr_pick u_rr_pick (
    .req  (req_q),
    .ptr  (ptr_q),
    .pick (fb_pick)
  );

  assign cand_ok = is_onehot3(skg) && ((skg & req_q) != '0);

`ifdef ARB3_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       tmo_q, tmo_d;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    err_d   = 1'b0;
`ifdef ARB3_TIMEOUT_EN
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req_q != '0) begin
          state_d = GRANT;
`ifdef ARB3_TIMEOUT_EN
          cnt_d   = '0;
`endif
          if (cand_ok) begin
            gnt_d = skg;
          end else begin
            gnt_d = fb_pick;
            err_d = 1'b1;
          end
        end
      end
      GRANT: begin
        // A non-owner rel bit is masked out by gnt_q.
        if ((rel & gnt_q) != '0) begin
          gnt_d   = '0;
          ptr_d   = rotl3(gnt_q);
          state_d = RECOVER;
        end
`ifdef ARB3_TIMEOUT_EN
        else if (cnt_q == HOLD_LAST) begin
          gnt_d   = '0;
          ptr_d   = rotl3(gnt_q);
          state_d = RECOVER;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      gnt_q   <= '0;
      ptr_q   <= 3'b001;
      err_q   <= 1'b0;
`ifdef ARB3_TIMEOUT_EN
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
`ifdef ARB3_TIMEOUT_EN
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  always_comb begin
    ctx = '0;
    ctx[CTX_REQ_LSB +: NCLIENT] = req_q;
    ctx[CTX_GNT_LSB +: NCLIENT] = gnt_q;
    ctx[CTX_PTR_LSB +: NCLIENT] = ptr_q;
    ctx[CTX_PND_LSB +: NCLIENT] = req_q & ~gnt_q;
  end

  assign gnt  = gnt_q;
  assign busy = (state_q == GRANT);
  assign err  = err_q;
`ifdef ARB3_TIMEOUT_EN
  assign tmo  = tmo_q;
`else
  assign tmo  = 1'b0;
`endif

endmodule

// File: doc/arbiter3_grant_ctrl.md
# arbiter3_grant_ctrl

Sequential wrapper for the 3-client arbiter Skolem network. It registers client requests and builds the 12-bit context vector that drives the combinational per-client Skolem grant functions. It consumes their 3 candidate grants, validates them, and issues registered one-hot grants held until the client releases. It falls back to internal round-robin whenever the candidates are illegal.

## Interface
Parameters:
- TIMEOUT, 16: maximum hold cycles per grant. Used only with the timeout feature; range 2..255.

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous, active-high reset
- req  input  3  per-client request level
- rel  input  3  per-client release pulse; honoured only for the current owner
- skg  input  3  candidate grants from the Skolem functions, combinational from ctx
- ctx  output 12  registered context vector; bit k drives Skolem input k+1
- gnt  output 3  registered one-hot grant, or zero
- busy output 1  high in GRANT state
- err  output 1  one-cycle pulse: candidate rejected, fallback used
- tmo  output 1  one-cycle pulse: forced release (timeout build only)

## Operation
- **ctx layout:**
  - [2:0] req_q, requests registered
  - [5:3] gnt
  - [8:6] ptr, one-hot round-robin pointer
  - [11:9] req_q & ~gnt, pending
- **Candidate legality:** skg is legal iff it is one-hot and skg & req_q is nonzero.
- **Fallback:** the first set bit of req_q, scanning from the ptr position upward mod 3.
- **IDLE:**
  - If req_q = 0, stay in IDLE.
  - Else, latch the legal skg, or the fallback with err = 1, into gnt, and go to GRANT.
- **GRANT:**
  - Hold gnt. skg is ignored.
  - rel[owner] = 1 → clear gnt, ptr ← rotate(owner) (next client), go to RECOVER.
  - rel on a non-owner bit is ignored.
- **RECOVER:** exactly one cycle with gnt = 0, so ctx settles; then IDLE.
- **Owner dropping req while granted:** the grant is held; only rel ends it.
- **Simultaneous rel[owner] and req[owner]:** release wins. The request re-arbitrates after RECOVER.
- **Reset mid-grant:** rst overrides everything and returns all state to reset values in one cycle. No err or tmo pulse is generated.

## Timing
- **Reset values:**
  - gnt = 0, busy = 0, err = 0, tmo = 0
  - ptr = 3'b001; req_q = 0, so ctx = 12'h040
  - state IDLE; hold counter 0
- **Request → grant latency:**
  - req rises at cycle t; req_q and ctx update at t+1.
  - skg is sampled at the end of t+1; gnt is visible at t+2.
- **Release:** rel at t → gnt = 0 at t+1 (RECOVER). The earliest new grant is t+3.
- **err:** asserted in the same cycle gnt first becomes valid, for 1 cycle.
- **Throughput:** at most one grant per 3 cycles.

## Configuration
- **ARB3_TIMEOUT_EN defined:**
  - An 8-bit hold counter resets to 0 on entry to GRANT and increments each GRANT cycle.
  - When it reaches TIMEOUT−1 without rel, the grant is dropped exactly as for a release: ptr rotates, state goes to RECOVER, and tmo pulses in the RECOVER cycle.
  - If rel arrives in that same cycle, it is treated as a normal release and tmo stays 0.
- **ARB3_TIMEOUT_EN undefined:** no counter, tmo tied to 0, and grants are held indefinitely.

## Structure
- **Package arbiter3_pkg:**
  - state enum {IDLE, GRANT, RECOVER}
  - NCLIENT = 3, CTX_W = 12
  - ctx field offset constants
  - function rr_pick(req, ptr)
  - function is_onehot3
- **Sub-module arbiter3_rr_pick:** combinational fallback selector. It is reused by the bench's reference model.

## Test plan
- **Reset:** rst held 2 cycles → gnt = 0, ctx = 12'h040, busy = 0, err = 0.
- **Legal candidate:** req = 3'b010 at t, skg driven 3'b010 → gnt = 3'b010 at t+2, err = 0, busy = 1.
- **Illegal candidate:**
  - Stimulus: req = 3'b101, ptr = 3'b010, skg = 3'b011 (not one-hot).
  - Expected: fallback gnt = 3'b100, err pulse.
- **Release and pointer:**
  - Stimulus: owner 0, rel = 3'b001 together with req[0] held.
  - Expected: gnt = 0 next cycle, ptr = 3'b010. Client 0 is regranted no earlier than 2 cycles later.
- **Foreign release and mid-grant reset:**
  - rel = 3'b100 while owner is 1 → gnt unchanged.
  - rst mid-GRANT → reset values next cycle.
- **Timeout (ARB3_TIMEOUT_EN, TIMEOUT = 4):**
  - Grant with no rel → gnt drops after 4 GRANT cycles, tmo = 1 for one cycle.
  - Same test with rel in the 4th cycle → tmo = 0.
